// File: rtl/prog_timer_pkg.sv
// Shared types and constants for the programmable timer.
package prog_timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam logic MODE_ONESHOT = 1'b0;
   localparam logic MODE_AUTO    = 1'b1;

endpackage : prog_timer_pkg

// File: rtl/prog_timer_counter.sv
// Run counter: synchronous clear, increment on enable, terminal-count compare.
module timer_counter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_clear,
   input  logic             i_enable,
   input  logic [WIDTH-1:0] i_period,
   output logic [WIDTH-1:0] o_count,
   output logic             o_tc_c
);

   logic [WIDTH-1:0] r_count;

   // Clear wins over enable; the count never exceeds period-1 so +1 cannot overflow.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable) begin
         r_count <= r_count + WIDTH'(1);
      end
   end

   assign o_count = r_count;
   assign o_tc_c  = (r_count == (i_period - WIDTH'(1)));

endmodule : timer_counter

// File: rtl/prog_timer.sv
// Programmable one-shot / auto-reload timer with pause and synchronous abort.
module prog_timer
   import prog_timer_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             CLK,
   input  logic             N_RESET,
   input  logic             START,
   input  logic             RESET,
   input  logic             PAUSE,
   input  logic             AUTO,
   input  logic [WIDTH-1:0] LOAD,
   output logic             READY,
   output logic             TICK,
   output logic             BUSY,
   output logic [WIDTH-1:0] COUNT
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_period;
   logic             r_mode;
   logic             r_ready;
   logic             r_tick;
   logic             r_busy;
   logic             w_capture;
   logic             w_clear;
   logic             w_enable;
   logic             w_tick_nxt;
   logic             w_tc;

   timer_counter #(.WIDTH(WIDTH)) u_counter (
      .i_clk    (CLK),
      .i_rst_n  (N_RESET),
      .i_clear  (w_clear),
      .i_enable (w_enable),
      .i_period (r_period),
      .o_count  (COUNT),
      .o_tc_c   (w_tc)
   );

   always_ff @(posedge CLK or negedge N_RESET) begin
      if (!N_RESET) begin
         r_state  <= ST_IDLE;
         r_period <= '0;
         r_mode   <= MODE_ONESHOT;
         r_ready  <= 1'b0;
         r_tick   <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_ready  <= (w_state_nxt == ST_DONE);
         r_busy   <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_HOLD);
         r_tick   <= w_tick_nxt;
         if (w_capture) begin
            r_period <= LOAD;
            r_mode   <= AUTO;
         end
      end
   end

   // HOLD with PAUSE low takes the same counting step as RUN, so each paused edge costs exactly one cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      w_clear     = 1'b0;
      w_enable    = 1'b0;
      w_tick_nxt  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (START && (LOAD != '0)) begin
               w_capture   = 1'b1;
               w_clear     = 1'b1;
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN, ST_HOLD: begin
            if (PAUSE) begin
               w_state_nxt = ST_HOLD;
            end else begin
               w_state_nxt = ST_RUN;
               if (w_tc) begin
                  w_tick_nxt = 1'b1;
                  if (r_mode == MODE_AUTO) begin
                     w_clear = 1'b1;
                  end else begin
                     w_state_nxt = ST_DONE;
                  end
               end else begin
                  w_enable = 1'b1;
               end
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_DONE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
      // Synchronous abort overrides everything above.
      if (RESET) begin
         w_state_nxt = ST_IDLE;
         w_capture   = 1'b0;
         w_clear     = 1'b1;
         w_enable    = 1'b0;
         w_tick_nxt  = 1'b0;
      end
   end

   assign READY = r_ready;
   assign TICK  = r_tick;
   assign BUSY  = r_busy;

endmodule : prog_timer

// File: tb/tb_prog_timer.sv
// Directed self-checking bench for prog_timer (WIDTH=8).
module tb_prog_timer;

   logic       CLK;
   logic       N_RESET;
   logic       START;
   logic       RESET;
   logic       PAUSE;
   logic       AUTO;
   logic [7:0] LOAD;
   logic       READY;
   logic       TICK;
   logic       BUSY;
   logic [7:0] COUNT;

   int n_vec = 0;
   int n_err = 0;

   prog_timer #(.WIDTH(8)) dut (
      .CLK     (CLK),
      .N_RESET (N_RESET),
      .START   (START),
      .RESET   (RESET),
      .PAUSE   (PAUSE),
      .AUTO    (AUTO),
      .LOAD    (LOAD),
      .READY   (READY),
      .TICK    (TICK),
      .BUSY    (BUSY),
      .COUNT   (COUNT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic r, input logic t,
                          input logic b, input logic [7:0] c);
      chk({tag, ".ready"}, 32'(READY), 32'(r));
      chk({tag, ".tick"},  32'(TICK),  32'(t));
      chk({tag, ".busy"},  32'(BUSY),  32'(b));
      chk({tag, ".count"}, 32'(COUNT), 32'(c));
   endtask

   task automatic start_run(input logic [7:0] p, input logic a);
      LOAD  = p;
      AUTO  = a;
      START = 1'b1;
      step();
      START = 1'b0;
   endtask

   task automatic abort();
      RESET = 1'b1;
      step();
      RESET = 1'b0;
   endtask

   initial begin
      N_RESET = 1'b0;
      START   = 1'b0;
      RESET   = 1'b0;
      PAUSE   = 1'b0;
      AUTO    = 1'b0;
      LOAD    = 8'd0;
      #12;
      chk_all("por", 1'b0, 1'b0, 1'b0, 8'd0);
      step();
      N_RESET = 1'b1;
      step();
      chk_all("idle", 1'b0, 1'b0, 1'b0, 8'd0);

      // One-shot LOAD=5: five busy cycles, then DONE with one tick at COUNT=4
      start_run(8'd5, 1'b0);
      chk_all("os5.c0", 1'b0, 1'b0, 1'b1, 8'd0);
      for (int i = 1; i < 5; i++) begin
         step();
         chk_all("os5.run", 1'b0, 1'b0, 1'b1, 8'(i));
      end
      step();
      chk_all("os5.done", 1'b1, 1'b1, 1'b0, 8'd4);
      LOAD  = 8'd9;
      START = 1'b1;
      step();
      START = 1'b0;
      chk_all("os5.hold_done", 1'b1, 1'b0, 1'b0, 8'd4);
      abort();
      chk_all("os5.reset", 1'b0, 1'b0, 1'b0, 8'd0);

      // Auto-reload LOAD=3: 0,1,2,0,... with tick after each wrap
      start_run(8'd3, 1'b1);
      AUTO = 1'b0;
      LOAD = 8'd7;
      chk_all("auto.c0", 1'b0, 1'b0, 1'b1, 8'd0);
      for (int i = 1; i < 10; i++) begin
         step();
         chk_all("auto.run", 1'b0, (i % 3) == 0, 1'b1, 8'(i % 3));
      end
      abort();
      chk_all("auto.reset", 1'b0, 1'b0, 1'b0, 8'd0);

      // LOAD=6, pause for four edges at COUNT=2: READY ten edges after START
      start_run(8'd6, 1'b0);
      step();
      step();
      chk_all("pause.c2", 1'b0, 1'b0, 1'b1, 8'd2);
      PAUSE = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk_all("pause.hold", 1'b0, 1'b0, 1'b1, 8'd2);
      end
      PAUSE = 1'b0;
      for (int i = 3; i < 6; i++) begin
         step();
         chk_all("pause.resume", 1'b0, 1'b0, 1'b1, 8'(i));
      end
      step();
      chk_all("pause.done", 1'b1, 1'b1, 1'b0, 8'd5);
      abort();

      // Pause at the terminal count blocks completion
      start_run(8'd2, 1'b0);
      step();
      PAUSE = 1'b1;
      step();
      chk_all("pause_tc.blocked", 1'b0, 1'b0, 1'b1, 8'd1);
      PAUSE = 1'b0;
      step();
      chk_all("pause_tc.done", 1'b1, 1'b1, 1'b0, 8'd1);
      abort();

      // RESET beats START in IDLE; RESET at COUNT=3 aborts the run
      LOAD  = 8'd4;
      START = 1'b1;
      RESET = 1'b1;
      step();
      chk_all("rst_start", 1'b0, 1'b0, 1'b0, 8'd0);
      RESET = 1'b0;
      step();
      START = 1'b0;
      chk_all("rst_run.c0", 1'b0, 1'b0, 1'b1, 8'd0);
      step();
      step();
      step();
      chk_all("rst_run.c3", 1'b0, 1'b0, 1'b1, 8'd3);
      abort();
      chk_all("rst_run.abort", 1'b0, 1'b0, 1'b0, 8'd0);
      step();
      chk_all("rst_run.idle", 1'b0, 1'b0, 1'b0, 8'd0);

      // Asynchronous reset mid-run at COUNT=100 of a 255 period
      start_run(8'd255, 1'b0);
      for (int i = 0; i < 100; i++) step();
      chk_all("nrst.c100", 1'b0, 1'b0, 1'b1, 8'd100);
      @(negedge CLK);
      N_RESET = 1'b0;
      #1;
      chk_all("nrst.async", 1'b0, 1'b0, 1'b0, 8'd0);
      step();
      N_RESET = 1'b1;
      step();
      step();
      chk_all("nrst.quiet", 1'b0, 1'b0, 1'b0, 8'd0);

      // LOAD=0 start is ignored
      start_run(8'd0, 1'b0);
      chk_all("load0", 1'b0, 1'b0, 1'b0, 8'd0);
      step();
      chk_all("load0.idle", 1'b0, 1'b0, 1'b0, 8'd0);

      // LOAD=1: one RUN cycle then completion
      start_run(8'd1, 1'b0);
      chk_all("load1.run", 1'b0, 1'b0, 1'b1, 8'd0);
      step();
      chk_all("load1.done", 1'b1, 1'b1, 1'b0, 8'd0);
      abort();

      // LOAD=255: READY after 255 RUN cycles, COUNT stops at 254
      start_run(8'd255, 1'b0);
      for (int i = 1; i < 255; i++) begin
         step();
         chk("load255.ready_low", 32'(READY), 32'd0);
      end
      chk_all("load255.c254", 1'b0, 1'b0, 1'b1, 8'd254);
      step();
      chk_all("load255.done", 1'b1, 1'b1, 1'b0, 8'd254);
      abort();
      chk_all("load255.reset", 1'b0, 1'b0, 1'b0, 8'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_prog_timer

// File: doc/prog_timer.md
PROG_TIMER -- requirements
Module: prog_timer

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the counter and period width in bits; legal range 2..32.
REQ-002 Port CLK, input, 1: SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 Port N_RESET, input, 1: SHALL be the asynchronous, active-low reset.
REQ-004 Port START, input, 1: SHALL be the request to begin a timing run, sampled in IDLE only.
REQ-005 Port RESET, input, 1: SHALL be a synchronous clear/abort, returning the FSM to IDLE.
REQ-006 Port PAUSE, input, 1: SHALL freeze counting while high.
REQ-007 Port AUTO, input, 1: SHALL select the mode, captured at START: 0 = one-shot, 1 = auto-reload.
REQ-008 Port LOAD, input, WIDTH: SHALL be the run period in cycles, captured at START.
REQ-009 Port READY, output, 1: SHALL be high only in state DONE.
REQ-010 Port TICK, output, 1: SHALL pulse for one cycle on every period completion.
REQ-011 Port BUSY, output, 1: SHALL be high in states RUN and HOLD.
REQ-012 Port COUNT, output, WIDTH: SHALL be the current count value.

Function
REQ-013 The FSM SHALL have four states: IDLE, RUN, HOLD, DONE.
REQ-014 IDLE: if START=1, RESET=0 and LOAD!=0, the FSM SHALL capture LOAD into the period register, capture AUTO into the mode register, clear COUNT, and enter RUN on the next edge.
REQ-015 IDLE: START with LOAD=0 SHALL be ignored; the FSM SHALL stay in IDLE.
REQ-016 RUN with PAUSE=0: COUNT SHALL increment by 1 per cycle.
REQ-017 RUN with PAUSE=0 and COUNT=period-1, one-shot mode: the FSM SHALL enter DONE, hold COUNT at period-1, and assert TICK for that one edge.
REQ-018 RUN with PAUSE=0 and COUNT=period-1, auto mode: COUNT SHALL wrap to 0, the FSM SHALL stay in RUN, and TICK SHALL be asserted.
REQ-019 TICK SHALL be registered and high in the cycle after the completing edge.
- One-shot: TICK coincides with the first cycle of READY.
REQ-020 Latency: with LOAD=P, START high at edge k and no pause, READY/TICK SHALL first be high after edge k+P.
REQ-021 PAUSE=1 in RUN: the FSM SHALL enter HOLD with COUNT frozen.
- In HOLD, PAUSE=0 SHALL return the FSM to RUN, and counting SHALL resume from the frozen value.
- Completion SHALL never occur in the cycle PAUSE is high.
REQ-022 DONE: the FSM SHALL remain in DONE with READY=1 until RESET=1, then go to IDLE.
REQ-023 RESET=1 in any state SHALL take priority over START, PAUSE and completion.
- Next state SHALL be IDLE, with COUNT=0, TICK=0 and READY=0.
REQ-024 START in RUN, HOLD or DONE SHALL be ignored.
- LOAD and AUTO changes after capture SHALL have no effect until the next run.
REQ-025 LOAD=1 SHALL give one RUN cycle, then completion.
- LOAD=all-ones SHALL give 2^WIDTH-1 RUN cycles.
- No arithmetic overflow SHALL occur in either case.
REQ-026 All outputs SHALL be glitch-free functions of registered state only.

Reset
REQ-027 N_RESET low SHALL asynchronously force:
- state=IDLE, COUNT=0, period=0, mode=0
- READY=0, TICK=0, BUSY=0
REQ-028 N_RESET assertion mid-run SHALL abort the run immediately.
- After release, the FSM SHALL require a fresh START.

Structure
REQ-029 Package prog_timer_pkg SHALL hold the state enumeration (IDLE, RUN, HOLD, DONE) and the mode constants.
REQ-030 The counter SHALL be a sub-module, timer_counter, parameterised on WIDTH.
- Ports: clear, enable, terminal-count output.
- The FSM SHALL remain in prog_timer.

Verification
REQ-031 WIDTH=8, LOAD=5, AUTO=0, START for 1 cycle -> BUSY for 5 cycles, then READY=1 with one TICK, COUNT=4; RESET -> IDLE next cycle.
REQ-032 LOAD=3, AUTO=1, run 10 cycles -> COUNT sequence 0,1,2,0,1,2,...; TICK high 3 times; READY never high.
REQ-033 LOAD=6, PAUSE high for 4 cycles at COUNT=2 -> COUNT holds at 2 in HOLD; READY first high 10 cycles after START.
REQ-034 RESET and START high together in IDLE, and RESET at COUNT=3 in RUN -> FSM ends in IDLE with COUNT=0 and no TICK.
REQ-035 N_RESET pulsed low mid-run at COUNT=100 with LOAD=255 -> all outputs 0 immediately; no activity until a new START.
REQ-036 LOAD=0 with START -> stays IDLE; LOAD=1 -> READY after one RUN cycle; LOAD=255 -> READY after 255 cycles.
